conv_window_sched: RTL and testbench

Controller that sequences the shared 3x3 convolution filter over a raster pixel stream. It buffers two image lines, assembles each 3x3 neighbourhood and issues it to the filter twice: once with the direction select horizontal, once vertical. It captures both results and presents them as a single paired output. It sits between the pixel source and the convolution filter, and is the only driver of the filter's inputs.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_line_buffer.sv | 31 +++
 rtl/conv_window_sched.sv | 209 ++++++++++++++++++++
 tb/tb_conv_window_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and constants for the 3x3 convolution scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        ISSUE_H = 3'd2,
        ISSUE_V = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    localparam logic DIR_H = 1'b1;
    localparam logic DIR_V = 1'b0;

    // Marker travelling alongside a filter request to identify its result.
    typedef struct packed {
        logic h;
        logic v;
        logic last;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buffer
// Brief    : Single-port line store, combinational read of the old word
//            while the same address is written at the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
    parameter int DEPTH = 640,
    parameter int DW    = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    assign rdata = r_mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_sched
// Brief    : Builds 3x3 windows from a raster stream, issues each to the shared
//            filter as a horizontal then vertical pass, and pairs the results.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_sched
    import conv_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int DW      = 12,
    parameter int FLT_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          flt_dir,
    output logic [DW-1:0] flt_x0,
    output logic [DW-1:0] flt_x1,
    output logic [DW-1:0] flt_x2,
    output logic [DW-1:0] flt_x3,
    output logic [DW-1:0] flt_x4,
    output logic [DW-1:0] flt_x5,
    output logic [DW-1:0] flt_x6,
    output logic [DW-1:0] flt_x7,
    output logic [DW-1:0] flt_x8,
    input  logic [DW-1:0] flt_out,
    output logic [DW-1:0] res_h,
    output logic [DW-1:0] res_v,
    output logic          res_valid,
    output logic          frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_COL_MIN  = CW'(2);
    localparam logic [RW-1:0] c_ROW_MIN  = RW'(2);

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [DW-1:0] r_win [9];
    logic          r_last_win;
    tag_t          r_tag [FLT_LAT];
    logic          r_pix_ready;
    logic          r_flt_dir;
    logic          r_res_valid;
    logic          r_frame_done;
    logic [DW-1:0] r_res_h;
    logic [DW-1:0] r_res_v;

    logic [DW-1:0] w_lb0_rd;
    logic [DW-1:0] w_lb1_rd;
    logic          w_accept;
    logic          w_issue;
    logic          w_last_pix;
    tag_t          w_tag_in;
    tag_t          w_tag_out;

    assign w_accept   = r_pix_ready & pix_valid;
    assign w_issue    = (r_row >= c_ROW_MIN) && (r_col >= c_COL_MIN);
    assign w_last_pix = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_tag_in   = '{h:    (r_state == ISSUE_H),
                          v:    (r_state == ISSUE_V),
                          last: (r_state == ISSUE_V) && r_last_win};
    assign w_tag_out  = r_tag[FLT_LAT-1];

    // lb0 holds the previous line, lb1 the one above it.
    conv_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb0 (
        .clk   (clk),
        .we    (w_accept),
        .addr  (r_col),
        .wdata (pix_in),
        .rdata (w_lb0_rd)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb1 (
        .clk   (clk),
        .we    (w_accept),
        .addr  (r_col),
        .wdata (w_lb0_rd),
        .rdata (w_lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_last_win   <= 1'b0;
            r_pix_ready  <= 1'b0;
            r_flt_dir    <= 1'b0;
            r_res_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_res_h      <= '0;
            r_res_v      <= '0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
            for (int i = 0; i < FLT_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_res_valid  <= 1'b0;
            r_frame_done <= 1'b0;

            r_tag[0] <= w_tag_in;
            for (int i = 1; i < FLT_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end

            // flt_out belongs to whichever request's tag is leaving the pipe.
            if (w_tag_out.h) begin
                r_res_h <= flt_out;
            end
            if (w_tag_out.v) begin
                r_res_v      <= flt_out;
                r_res_valid  <= 1'b1;
                r_frame_done <= w_tag_out.last;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_col       <= '0;
                        r_row       <= '0;
                        r_last_win  <= 1'b0;
                        r_pix_ready <= 1'b1;
                        r_state     <= RUN;
                        for (int i = 0; i < 9; i++) begin
                            r_win[i] <= '0;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_win[0] <= r_win[1];
                        r_win[1] <= r_win[2];
                        r_win[2] <= w_lb1_rd;
                        r_win[3] <= r_win[4];
                        r_win[4] <= r_win[5];
                        r_win[5] <= w_lb0_rd;
                        r_win[6] <= r_win[7];
                        r_win[7] <= r_win[8];
                        r_win[8] <= pix_in;
                        if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_issue) begin
                            r_state     <= ISSUE_H;
                            r_pix_ready <= 1'b0;
                            r_flt_dir   <= DIR_H;
                            r_last_win  <= w_last_pix;
                        end
                    end
                end
                ISSUE_H: begin
                    r_state   <= ISSUE_V;
                    r_flt_dir <= DIR_V;
                end
                ISSUE_V: begin
                    if (r_last_win) begin
                        r_state <= FLUSH;
                    end else begin
                        r_state     <= RUN;
                        r_pix_ready <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (w_tag_out.v && w_tag_out.last) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_pix_ready <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready  = r_pix_ready;
    assign flt_dir    = r_flt_dir;
    assign flt_x0     = r_win[0];
    assign flt_x1     = r_win[1];
    assign flt_x2     = r_win[2];
    assign flt_x3     = r_win[3];
    assign flt_x4     = r_win[4];
    assign flt_x5     = r_win[5];
    assign flt_x6     = r_win[6];
    assign flt_x7     = r_win[7];
    assign flt_x8     = r_win[8];
    assign res_h      = r_res_h;
    assign res_v      = r_res_v;
    assign res_valid  = r_res_valid;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_sched
// Brief    : Scoreboard bench for conv_window_sched, two instances (FLT_LAT 1/3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_sched;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int DW    = 12;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int NRES  = (W - 2) * (H - 2);
    localparam int WV    = 9 * DW;

    typedef struct packed {
        logic [DW-1:0] h;
        logic [DW-1:0] v;
        logic          last;
        int            ed;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_in = '0;

    logic          a_ready, a_dir, a_rv, a_fd, b_ready, b_dir, b_rv, b_fd;
    logic [DW-1:0] a_x [9];
    logic [DW-1:0] b_x [9];
    logic [DW-1:0] a_rh, a_rvl, b_rh, b_rvl, a_fout, b_fout;
    logic [WV-1:0] a_vec, b_vec;
    logic [DW-1:0] a_pipe [LAT_A] = '{default: '0};
    logic [DW-1:0] b_pipe [LAT_B] = '{default: '0};

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_edge = 0;
    int            cnt_a = 0, cnt_b = 0, fd_a = 0, fd_b = 0;
    int            flt_mode = 0;
    int            fstart = 0;
    int            rel_a[$];
    int            rel1[$];
    exp_t          qa[$];
    exp_t          qb[$];
    logic [WV-1:0] qw[$];
    logic [WV-1:0] held = '0;
    bit            chk_v = 1'b0;
    logic [DW-1:0] img [W*H];

    always #5 clk = ~clk;
    always @(posedge clk) n_edge <= n_edge + 1;

    assign a_vec = {a_x[0], a_x[1], a_x[2], a_x[3], a_x[4], a_x[5], a_x[6], a_x[7], a_x[8]};
    assign b_vec = {b_x[0], b_x[1], b_x[2], b_x[3], b_x[4], b_x[5], b_x[6], b_x[7], b_x[8]};

    // Filter result for a packed window (x0 in the top bits).
    function automatic logic [DW-1:0] flt_f(input int mode, input logic dir, input logic [WV-1:0] v);
        int acc = 0;
        if (mode == 0) return dir ? v[DW-1:0] : v[WV-1 -: DW];
        for (int i = 0; i < 9; i++) acc += (dir ? (i + 1) : (9 - i)) * int'(v[(8-i)*DW +: DW]);
        return dir ? DW'(acc) : (DW'(acc) ^ DW'(12'h5A3));
    endfunction

    always @(posedge clk) begin
        a_pipe[0] <= flt_f(flt_mode, a_dir, a_vec);
        for (int i = 1; i < LAT_A; i++) a_pipe[i] <= a_pipe[i-1];
    end
    always @(posedge clk) begin
        b_pipe[0] <= flt_f(flt_mode, b_dir, b_vec);
        for (int i = 1; i < LAT_B; i++) b_pipe[i] <= b_pipe[i-1];
    end
    assign a_fout = a_pipe[LAT_A-1];
    assign b_fout = b_pipe[LAT_B-1];

    conv_window_sched #(.IMG_W(W), .IMG_H(H), .DW(DW), .FLT_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(a_ready), .flt_dir(a_dir),
        .flt_x0(a_x[0]), .flt_x1(a_x[1]), .flt_x2(a_x[2]), .flt_x3(a_x[3]), .flt_x4(a_x[4]),
        .flt_x5(a_x[5]), .flt_x6(a_x[6]), .flt_x7(a_x[7]), .flt_x8(a_x[8]),
        .flt_out(a_fout), .res_h(a_rh), .res_v(a_rvl), .res_valid(a_rv), .frame_done(a_fd)
    );

    conv_window_sched #(.IMG_W(W), .IMG_H(H), .DW(DW), .FLT_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(b_ready), .flt_dir(b_dir),
        .flt_x0(b_x[0]), .flt_x1(b_x[1]), .flt_x2(b_x[2]), .flt_x3(b_x[3]), .flt_x4(b_x[4]),
        .flt_x5(b_x[5]), .flt_x6(b_x[6]), .flt_x7(b_x[7]), .flt_x8(b_x[8]),
        .flt_out(b_fout), .res_h(b_rh), .res_v(b_rvl), .res_valid(b_rv), .frame_done(b_fd)
    );

    task automatic check_v(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, n_edge);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        check_v(name, 160'(act), 160'(exp));
    endtask

    // Neighbourhood of image position (r,c): rows r-2..r, cols c-2..c.
    function automatic logic [WV-1:0] exp_win(input int r, input int c);
        logic [WV-1:0] v = '0;
        for (int i = 0; i < 9; i++) v = {v[WV-DW-1:0], img[(r - 2 + i / 3) * W + c - 2 + i % 3]};
        return v;
    endfunction

    task automatic push_exp(input int r, input int c, input int acc_edge);
        logic [WV-1:0] w;
        exp_t e;
        if (r < 2 || c < 2) return;
        w = exp_win(r, c);
        qw.push_back(w);
        e.h    = flt_f(flt_mode, 1'b1, w);
        e.v    = flt_f(flt_mode, 1'b0, w);
        e.last = (r == H - 1) && (c == W - 1);
        e.ed   = acc_edge + 2 + LAT_A;
        qa.push_back(e);
        e.ed   = acc_edge + 2 + LAT_B;
        qb.push_back(e);
    endtask

    task automatic monitor_step();
        exp_t e;
        if (a_rv) begin
            cnt_a++;
            rel_a.push_back(n_edge - fstart);
            if (qa.size() == 0) check_i("a_unexpected_res", int'(a_rv), 0);
            else begin
                e = qa.pop_front();
                check_v("a_res_h", 160'(a_rh), 160'(e.h));
                check_v("a_res_v", 160'(a_rvl), 160'(e.v));
                check_i("a_frame_done", int'(a_fd), int'(e.last));
                check_i("a_res_edge", n_edge, e.ed);
            end
        end else if (qa.size() != 0 && qa[0].ed < n_edge) begin
            check_i("a_res_missing", int'(a_rv), 1);
            void'(qa.pop_front());
        end
        if (a_fd) fd_a++;
        if (a_fd && !a_rv) check_i("a_fd_alone", int'(a_fd), 0);

        if (b_rv) begin
            cnt_b++;
            if (qb.size() == 0) check_i("b_unexpected_res", int'(b_rv), 0);
            else begin
                e = qb.pop_front();
                check_v("b_res_h", 160'(b_rh), 160'(e.h));
                check_v("b_res_v", 160'(b_rvl), 160'(e.v));
                check_i("b_frame_done", int'(b_fd), int'(e.last));
                check_i("b_res_edge", n_edge, e.ed);
            end
        end else if (qb.size() != 0 && qb[0].ed < n_edge) begin
            check_i("b_res_missing", int'(b_rv), 1);
            void'(qb.pop_front());
        end
        if (b_fd) fd_b++;
        if (b_fd && !b_rv) check_i("b_fd_alone", int'(b_fd), 0);

        if (chk_v) begin
            chk_v = 1'b0;
            check_i("a_dir_second", int'(a_dir), 0);
            check_i("b_dir_second", int'(b_dir), 0);
            check_v("a_win_hold", 160'(a_vec), 160'(held));
            check_v("b_win_hold", 160'(b_vec), 160'(held));
        end else if (a_dir || b_dir) begin
            if (qw.size() == 0) check_i("unexpected_issue", int'(a_dir | b_dir), 0);
            else begin
                held = qw.pop_front();
                check_i("a_dir_first", int'(a_dir), 1);
                check_i("b_dir_first", int'(b_dir), 1);
                check_v("a_win", 160'(a_vec), 160'(held));
                check_v("b_win", 160'(b_vec), 160'(held));
                chk_v = 1'b1;
            end
        end
    endtask

    task automatic send_pix(input int k, input bit mid_start);
        bit acc = 1'b0;
        pix_valid = 1'b1;
        pix_in    = img[k];
        start     = mid_start;
        for (int g = 0; g < 40 && !acc; g++) begin
            if (a_ready) begin
                push_exp(k / W, k % W, n_edge + 1);
                acc = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!acc) check_i("accept_timeout", int'(a_ready), 1);
        pix_valid = 1'b0;
        pix_in    = DW'($urandom);
    endtask

    task automatic start_frame();
        cnt_a = 0; cnt_b = 0; fd_a = 0; fd_b = 0;
        rel_a.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        fstart = n_edge;
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 80 && (qa.size() + qb.size() + qw.size()) != 0; g++) begin
            @(posedge clk); #1;
        end
        check_i("drain_in_time", qa.size() + qb.size() + qw.size(), 0);
        qa.delete(); qb.delete(); qw.delete();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic run_frame(input int stall_idx, input int stall_len, input int start_idx, input bit gaps);
        start_frame();
        for (int k = 0; k < W * H; k++) begin
            if (k == stall_idx) repeat (stall_len) begin @(posedge clk); #1; end
            else if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            send_pix(k, k == start_idx);
        end
        wait_drain();
        check_i("a_res_count", cnt_a, NRES);
        check_i("b_res_count", cnt_b, NRES);
        check_i("a_frame_done_count", fd_a, 1);
        check_i("b_frame_done_count", fd_b, 1);
    endtask

    task automatic fill_seq();
        for (int k = 0; k < W * H; k++) img[k] = DW'(k + 1);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < W * H; k++) img[k] = DW'($urandom_range(0, 4095));
    endtask

    initial begin
        int sa, sb;
        fork
            forever begin
                @(negedge clk);
                if (!rst) monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_v("a_reset_state", 160'({a_ready, a_dir, a_rv, a_fd, a_rh, a_rvl, a_vec}), 160'(0));
        check_v("b_reset_state", 160'({b_ready, b_dir, b_rv, b_fd, b_rh, b_rvl, b_vec}), 160'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Directed 1..16 frame, then the same with a 5-cycle stall mid-row.
        flt_mode = 0;
        fill_seq();
        run_frame(-1, 0, -1, 1'b0);
        rel1 = rel_a;
        run_frame(6, 5, -1, 1'b0);
        check_i("stall_res_count", rel_a.size(), rel1.size());
        for (int i = 0; i < rel_a.size() && i < rel1.size(); i++) check_i("stall_delay", rel_a[i] - rel1[i], 5);

        // Random pixels with a start pulse while running.
        flt_mode = 1;
        fill_rand();
        run_frame(-1, 0, int'($urandom_range(3, 12)), 1'b1);

        // Reset after the second result of the LAT=1 instance.
        flt_mode = 0;
        fill_seq();
        start_frame();
        for (int k = 0; k < W * H; k++) begin
            send_pix(k, 1'b0);
            if (cnt_a >= 2) break;
        end
        rst = 1'b1;
        qa.delete(); qb.delete(); qw.delete();
        chk_v = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_v("a_after_rst", 160'({a_ready, a_dir, a_rv, a_fd, a_rh, a_rvl, a_vec}), 160'(0));
        check_v("b_after_rst", 160'({b_ready, b_dir, b_rv, b_fd, b_rh, b_rvl, b_vec}), 160'(0));
        sa = cnt_a; sb = cnt_b;
        repeat (10) @(negedge clk);
        check_i("a_no_res_after_rst", cnt_a, sa);
        check_i("b_no_res_after_rst", cnt_b, sb);
        @(posedge clk); #1;
        run_frame(-1, 0, -1, 1'b0);

        flt_mode = 1;
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            run_frame(-1, 0, -1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
